// File: rtl/ace_pkg.sv
// Shared ACE snoop types: cache line states, snoop opcodes, CR response encoding
// and the AC/CR/CD channel bundles exchanged with the coherency crossbar.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 64;

  typedef enum logic [2:0] {
    INVALID,
    SC,
    SD,
    UC,
    UD
  } cache_state_t;

  // ACSNOOP encodings this responder understands; anything else is answered as a miss.
  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    logic [3:0]              snoop;
  } ac_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } cd_t;

  typedef struct packed {
    logic ac_valid;
    ac_t  ac;
    logic cr_ready;
    logic cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic    ac_ready;
    logic    cr_valid;
    crresp_t cr_resp;
    logic    cd_valid;
    cd_t     cd;
  } snoop_resp_t;

endpackage

// File: rtl/ccu_snoop_policy.sv
// Combinational snoop policy: maps (snoop opcode, current line state) to the CR
// response and the line-state update that must be committed afterwards.
module ccu_snoop_policy
  import ace_pkg::*;
(
  input  logic [3:0]   snoop,
  input  cache_state_t state,
  output crresp_t      resp,
  output logic         do_update,
  output cache_state_t new_state
);

  logic is_dirty;
  logic is_unique;

  assign is_dirty  = (state == SD) || (state == UD);
  assign is_unique = (state == UC) || (state == UD);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    resp      = '0;
    do_update = 1'b0;
    new_state = state;
    if (state != INVALID) begin
      case (snoop)
        SNP_READ_ONCE: begin
          resp.data_transfer = 1'b1;
          resp.is_shared     = 1'b1;
          resp.was_unique    = is_unique;
        end
        SNP_READ_SHARED, SNP_READ_CLEAN: begin
          resp.data_transfer = 1'b1;
          resp.is_shared     = 1'b1;
          resp.pass_dirty    = is_dirty;
          resp.was_unique    = is_unique;
          do_update          = 1'b1;
          new_state          = SC;
        end
        SNP_READ_UNIQUE: begin
          resp.data_transfer = 1'b1;
          resp.pass_dirty    = is_dirty;
          resp.was_unique    = is_unique;
          do_update          = 1'b1;
          new_state          = INVALID;
        end
        SNP_CLEAN_INVALID: begin
          resp.data_transfer = is_dirty;
          resp.pass_dirty    = is_dirty;
          resp.was_unique    = is_unique;
          do_update          = 1'b1;
          new_state          = INVALID;
        end
        SNP_MAKE_INVALID: begin
          resp.was_unique = is_unique;
          do_update       = 1'b1;
          new_state       = INVALID;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: one snoop at a time through tag lookup, CR
// response, optional CD line transfer via a one-entry skid, then state update.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int unsigned AXLEN            = 1,
  parameter int unsigned AddrWidth        = AceAddrWidth,
  parameter int unsigned DataWidth        = AceDataWidth,
  parameter type         mst_snoop_req_t  = snoop_req_t,
  parameter type         mst_snoop_resp_t = snoop_resp_t,
  localparam int unsigned BeatWidth       = (AXLEN > 0) ? $clog2(AXLEN + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  mst_snoop_req_t       snoop_req_i,
  output mst_snoop_resp_t      snoop_resp_o,
  output logic                 tag_req_o,
  output logic [AddrWidth-1:0] tag_addr_o,
  input  logic                 tag_gnt_i,
  input  cache_state_t         tag_state_i,
  output logic                 data_req_o,
  output logic [BeatWidth-1:0] data_beat_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 upd_valid_o,
  output cache_state_t         upd_state_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVAL,
    S_RESP,
    S_CD,
    S_UPD
  } fsm_t;

  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(AXLEN);

  fsm_t                 state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  crresp_t              resp_q;
  logic                 upd_q;
  cache_state_t         upd_state_q;

  logic [BeatWidth-1:0] req_beat_q, send_beat_q;
  logic                 req_done_q, pend_q, skid_valid_q;
  logic [DataWidth-1:0] skid_data_q;

  crresp_t      pol_resp;
  logic         pol_upd;
  cache_state_t pol_state;

  logic ac_hs, cr_hs, cd_valid, cd_hs, send_last, issue;

  ccu_snoop_policy u_policy (
    .snoop     (snoop_q),
    .state     (tag_state_i),
    .resp      (pol_resp),
    .do_update (pol_upd),
    .new_state (pol_state)
  );

  assign ac_hs     = (state_q == S_IDLE) && snoop_req_i.ac_valid;
  assign cr_hs     = (state_q == S_RESP) && snoop_req_i.cr_ready;
  assign cd_valid  = pend_q || skid_valid_q;
  assign cd_hs     = cd_valid && snoop_req_i.cd_ready;
  assign send_last = (send_beat_q == LastBeat);
  // Keep at most one beat in flight: request only when the slot frees up this cycle.
  assign issue     = (state_q == S_CD) && !req_done_q
                     && ((!pend_q && !skid_valid_q) || cd_hs);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (snoop_req_i.ac_valid) state_d = S_LOOKUP;
      S_LOOKUP: if (tag_gnt_i) state_d = S_EVAL;
      S_EVAL:   state_d = S_RESP;
      S_RESP: begin
        if (snoop_req_i.cr_ready) begin
          if (resp_q.data_transfer) state_d = S_CD;
          else if (upd_q)           state_d = S_UPD;
          else                      state_d = S_IDLE;
        end
      end
      S_CD:     if (cd_hs && send_last) state_d = upd_q ? S_UPD : S_IDLE;
      S_UPD:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (state_q == S_IDLE);
    snoop_resp_o.cr_valid = (state_q == S_RESP);
    snoop_resp_o.cr_resp  = resp_q;
    snoop_resp_o.cd_valid = cd_valid;
    snoop_resp_o.cd.data  = skid_valid_q ? skid_data_q : (pend_q ? data_i : '0);
    snoop_resp_o.cd.last  = cd_valid && send_last;
    tag_req_o             = (state_q == S_LOOKUP);
    tag_addr_o            = addr_q;
    data_req_o            = issue;
    data_beat_o           = req_beat_q;
    upd_valid_o           = (state_q == S_UPD);
    upd_state_o           = upd_state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      snoop_q     <= '0;
      resp_q      <= '0;
      upd_q       <= 1'b0;
      upd_state_q <= INVALID;
    end else begin
      if (ac_hs) begin
        addr_q  <= snoop_req_i.ac.addr;
        snoop_q <= snoop_req_i.ac.snoop;
      end
      if (state_q == S_EVAL) begin
        resp_q      <= pol_resp;
        upd_q       <= pol_upd;
        upd_state_q <= pol_state;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_beat_q   <= '0;
      send_beat_q  <= '0;
      req_done_q   <= 1'b0;
      pend_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      pend_q <= issue;
      if (cr_hs) req_done_q <= 1'b0;
      if (issue) begin
        req_beat_q <= (req_beat_q == LastBeat) ? '0 : req_beat_q + 1'b1;
        if (req_beat_q == LastBeat) req_done_q <= 1'b1;
      end
      if (cd_hs) send_beat_q <= send_last ? '0 : send_beat_q + 1'b1;
      // Returning data that is not taken this cycle parks in the skid register.
      if (pend_q && !snoop_req_i.cd_ready) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= data_i;
      end else if (skid_valid_q && snoop_req_i.cd_ready) begin
        skid_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: directed vector table, reset-abort sequence and
// randomized snoops checked against a rule-level reference model.
module tb_ace_snoop_responder;
  import ace_pkg::*;

  localparam int unsigned AXLEN     = 1;
  localparam int unsigned BeatWidth = (AXLEN > 0) ? $clog2(AXLEN + 1) : 1;
  localparam int          NBeats    = AXLEN + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  snoop_req_t           snoop_req_i;
  snoop_resp_t          snoop_resp_o;
  logic                 tag_req_o;
  logic [63:0]          tag_addr_o;
  logic                 tag_gnt_i;
  cache_state_t         tag_state_i;
  logic                 data_req_o;
  logic [BeatWidth-1:0] data_beat_o;
  logic [63:0]          data_i;
  logic                 upd_valid_o;
  cache_state_t         upd_state_o;

  ace_snoop_responder #(.AXLEN(AXLEN)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .snoop_req_i  (snoop_req_i),
    .snoop_resp_o (snoop_resp_o),
    .tag_req_o    (tag_req_o),
    .tag_addr_o   (tag_addr_o),
    .tag_gnt_i    (tag_gnt_i),
    .tag_state_i  (tag_state_i),
    .data_req_o   (data_req_o),
    .data_beat_o  (data_beat_o),
    .data_i       (data_i),
    .upd_valid_o  (upd_valid_o),
    .upd_state_o  (upd_state_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    cache_state_t st;
    int           gnt_dly;
    int           cr_dly;
    logic [15:0]  rdy;
    logic [4:0]   exp_resp;
    int           exp_beats;
    bit           exp_upd;
    cache_state_t exp_state;
  } vec_t;

  // Observations of the most recent snoop.
  logic [63:0]  line_base;
  logic [4:0]   got_resp;
  logic [63:0]  got_data[$];
  logic         got_last[$];
  int           got_cdv, got_upd;
  cache_state_t got_ust;
  bit           bad_addr, bad_cr, bad_stable, bad_order, timed_out;
  int           ac_cyc, cr_first_cyc, cr_hs_cyc, idle_cyc;

  task automatic run_snoop(input logic [3:0] op, input cache_state_t st, input int gnt_dly,
                           input int cr_dly, input logic [15:0] rdy, input logic [63:0] addr,
                           input bit abort_at_cd);
    int                   req_cnt = 0;
    int                   crv_cnt = 0;
    int                   budget  = 0;
    bit                   gnt_last = 0, ac_done = 0, cr_done = 0, done = 0;
    bit                   dreq_last = 0, prev_stall = 0;
    logic [BeatWidth-1:0] beat_last = '0;
    logic [63:0]          prev_data = '0;
    logic                 prev_last = 1'b0;
    got_data.delete(); got_last.delete();
    got_resp = '0; got_cdv = 0; got_upd = 0; got_ust = INVALID;
    bad_addr = 0; bad_cr = 0; bad_stable = 0; bad_order = 0; timed_out = 0;
    ac_cyc = 0; cr_first_cyc = 0; cr_hs_cyc = 0; idle_cyc = 0;
    while (!done) begin
      @(negedge clk_i);
      snoop_req_i.ac_valid  = !ac_done;
      snoop_req_i.ac.addr   = addr;
      snoop_req_i.ac.snoop  = op;
      tag_gnt_i             = (req_cnt >= gnt_dly);
      tag_state_i           = gnt_last ? st : INVALID;
      snoop_req_i.cr_ready  = (crv_cnt >= cr_dly);
      snoop_req_i.cd_ready  = rdy[(got_cdv < 15) ? got_cdv : 15];
      data_i                = dreq_last ? line_base + 64'(beat_last) : 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      gnt_last = tag_req_o && tag_gnt_i;
      if (tag_req_o) begin
        req_cnt++;
        if (tag_addr_o !== addr) bad_addr = 1;
      end
      if (!ac_done) begin
        if (snoop_resp_o.ac_ready) begin
          ac_done = 1;
          ac_cyc  = cyc;
        end
      end else if (snoop_resp_o.ac_ready) begin
        idle_cyc = cyc;
        done     = 1;
      end
      if (snoop_resp_o.cd_valid) begin
        if (!cr_done) bad_order = 1;
        if (prev_stall && ({snoop_resp_o.cd.data, snoop_resp_o.cd.last} !== {prev_data, prev_last}))
          bad_stable = 1;
        got_cdv++;
        if (snoop_req_i.cd_ready) begin
          got_data.push_back(snoop_resp_o.cd.data);
          got_last.push_back(snoop_resp_o.cd.last);
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_data  = snoop_resp_o.cd.data;
          prev_last  = snoop_resp_o.cd.last;
        end
        if (abort_at_cd) begin
          rst_ni = 1'b0;
          done   = 1;
        end
      end else if (prev_stall) begin
        bad_stable = 1;
      end
      if (snoop_resp_o.cr_valid) begin
        if (cr_done) bad_cr = 1;
        if (crv_cnt == 0) begin
          got_resp     = snoop_resp_o.cr_resp;
          cr_first_cyc = cyc;
        end else if (snoop_resp_o.cr_resp !== got_resp) begin
          bad_cr = 1;
        end
        crv_cnt++;
        if (snoop_req_i.cr_ready) begin
          cr_done   = 1;
          cr_hs_cyc = cyc;
        end
      end else if (crv_cnt > 0 && !cr_done) begin
        bad_cr = 1;
      end
      if (upd_valid_o) begin
        got_upd++;
        got_ust = upd_state_o;
      end
      dreq_last = data_req_o;
      beat_last = data_beat_o;
      budget++;
      if (budget > 200) begin
        timed_out = 1;
        done      = 1;
      end
    end
  endtask

  task automatic check_txn(input string id, input logic [4:0] er, input int eb, input bit eu,
                           input cache_state_t es, input logic [15:0] rdy);
    check({id, " timeout"}, 64'(timed_out), 64'(0));
    check({id, " cr_resp"}, 64'(got_resp), 64'(er));
    check({id, " cd_beats"}, 64'(got_data.size()), 64'(eb));
    for (int i = 0; i < eb && i < got_data.size(); i++) begin
      check($sformatf("%s cd_data[%0d]", id, i), got_data[i], line_base + 64'(i));
      check($sformatf("%s cd_last[%0d]", id, i), 64'(got_last[i]), 64'(i == AXLEN));
    end
    check({id, " upd_count"}, 64'(got_upd), 64'(eu));
    if (eu) check({id, " upd_state"}, 64'(got_ust), 64'(es));
    check({id, " stability"}, 64'({bad_addr, bad_cr, bad_stable, bad_order}), 64'(0));
    check({id, " cr_latency_ge3"}, 64'((cr_first_cyc - ac_cyc) >= 3), 64'(1));
    if (eb == 0) check({id, " idle_return"}, 64'(idle_cyc - cr_hs_cyc), 64'(eu ? 2 : 1));
    if (eb > 0 && rdy == 16'hFFFF) check({id, " cd_rate"}, 64'(got_cdv), 64'(eb));
  endtask

  // Rule-level model of the snoop policy: each opcode names which rule governs
  // data transfer and dirty passing, whether the copy stays shared, and the end state.
  function automatic void ref_model(input logic [3:0] op, input cache_state_t st,
                                    output logic [4:0] resp, output int beats,
                                    output bit upd, output cache_state_t ns);
    bit hit   = (st != INVALID);
    bit dirty = (st == SD) || (st == UD);
    bit uniq  = (st == UC) || (st == UD);
    int dt_rule = 0, pd_rule = 0;  // 0 never, 1 always, 2 only when dirty
    bit shared = 0, known = 1, keeps_state = 0;
    cache_state_t target = INVALID;
    bit dt, pd;
    case (op)
      SNP_READ_ONCE:                  begin dt_rule = 1; shared = 1; keeps_state = 1; end
      SNP_READ_SHARED, SNP_READ_CLEAN: begin dt_rule = 1; pd_rule = 2; shared = 1; target = SC; end
      SNP_READ_UNIQUE:                begin dt_rule = 1; pd_rule = 2; end
      SNP_CLEAN_INVALID:              begin dt_rule = 2; pd_rule = 2; end
      SNP_MAKE_INVALID:               ;
      default:                        known = 0;
    endcase
    ns = st;
    if (!hit || !known) begin
      resp  = '0;
      beats = 0;
      upd   = 0;
    end else begin
      dt    = (dt_rule == 1) || (dt_rule == 2 && dirty);
      pd    = (pd_rule == 1) || (pd_rule == 2 && dirty);
      resp  = {uniq, shared, pd, 1'b0, dt};
      beats = dt ? NBeats : 0;
      upd   = !keeps_state;
      if (upd) ns = target;
    end
  endfunction

  vec_t vecs[10];

  initial begin
    logic [63:0]  addr;
    logic [4:0]   r_resp;
    int           r_beats;
    bit           r_upd;
    cache_state_t r_ns;
    logic [3:0]   ops[10];

    vecs[0] = '{SNP_READ_SHARED,   UD,      0, 0, 16'hFFFF, 5'b11101, 2, 1, SC};
    vecs[1] = '{SNP_READ_UNIQUE,   INVALID, 0, 0, 16'hFFFF, 5'b00000, 0, 0, INVALID};
    vecs[2] = '{SNP_CLEAN_INVALID, UC,      0, 0, 16'hFFFF, 5'b10000, 0, 1, INVALID};
    vecs[3] = '{SNP_READ_ONCE,     SD,      0, 0, 16'hFFF9, 5'b01001, 2, 0, INVALID};
    vecs[4] = '{SNP_READ_SHARED,   UD,      4, 3, 16'hFFFF, 5'b11101, 2, 1, SC};
    vecs[5] = '{SNP_MAKE_INVALID,  SD,      1, 0, 16'hFFFF, 5'b00000, 0, 1, INVALID};
    vecs[6] = '{SNP_READ_CLEAN,    SC,      0, 2, 16'hFFFE, 5'b01001, 2, 1, SC};
    vecs[7] = '{SNP_READ_UNIQUE,   UD,      2, 1, 16'hFFFB, 5'b10101, 2, 1, INVALID};
    vecs[8] = '{SNP_CLEAN_INVALID, SD,      0, 0, 16'hFFFF, 5'b00101, 2, 1, INVALID};
    vecs[9] = '{4'b0011,           UD,      0, 0, 16'hFFFF, 5'b00000, 0, 0, INVALID};

    ops = '{SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_UNIQUE, SNP_CLEAN_INVALID,
            SNP_MAKE_INVALID, 4'b0011, 4'b1000, 4'b1110, 4'b0100};

    rst_ni      = 1'b0;
    snoop_req_i = '0;
    tag_gnt_i   = 1'b0;
    tag_state_i = INVALID;
    data_i      = '0;
    line_base   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset valids/resp/last",
          64'({snoop_resp_o.cr_valid, snoop_resp_o.cd_valid, tag_req_o, data_req_o, upd_valid_o,
               snoop_resp_o.cr_resp, snoop_resp_o.cd.last}), 64'(0));
    check("reset cd_data", snoop_resp_o.cd.data, 64'(0));
    check("reset ac_ready", 64'(snoop_resp_o.ac_ready), 64'(1));
    check("reset beat", 64'(data_beat_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      line_base = 64'hA0 + 64'(i) * 64'h100;
      addr      = 64'h8000_0000_0000_0040 + 64'(i) * 64'h40;
      run_snoop(vecs[i].op, vecs[i].st, vecs[i].gnt_dly, vecs[i].cr_dly, vecs[i].rdy, addr, 0);
      check_txn($sformatf("vec%0d", i), vecs[i].exp_resp, vecs[i].exp_beats, vecs[i].exp_upd,
                vecs[i].exp_state, vecs[i].rdy);
    end

    // Reset arrives while CD beat 0 is on the bus.
    line_base = 64'hC0;
    run_snoop(SNP_READ_SHARED, UD, 0, 0, 16'hFFFF, 64'h1234_5678_0000_0080, 1);
    check("abort reached cd", 64'(got_cdv), 64'(1));
    @(posedge clk_i);
    #1;
    check("abort valids",
          64'({snoop_resp_o.cr_valid, snoop_resp_o.cd_valid, tag_req_o, data_req_o, upd_valid_o}),
          64'(0));
    @(posedge clk_i);
    #1;
    check("abort no upd", 64'(upd_valid_o), 64'(0));
    check("abort idle", 64'(snoop_resp_o.ac_ready), 64'(1));
    check("abort beat", 64'(data_beat_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    line_base = 64'hA0;
    run_snoop(vecs[0].op, vecs[0].st, 0, 0, 16'hFFFF, 64'h1234_5678_0000_0080, 0);
    check_txn("post_abort", vecs[0].exp_resp, vecs[0].exp_beats, vecs[0].exp_upd,
              vecs[0].exp_state, 16'hFFFF);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]   op;
      cache_state_t st;
      logic [15:0]  rdy;
      int           gd, cd;
      op  = ops[$urandom_range(0, 9)];
      st  = cache_state_t'($urandom_range(0, 4));
      gd  = $urandom_range(0, 3);
      cd  = $urandom_range(0, 3);
      rdy = 16'($urandom) | 16'h8000;
      if (n % 4 == 0) rdy = 16'hFFFF;
      line_base = {$urandom, $urandom};
      addr      = {$urandom, $urandom};
      ref_model(op, st, r_resp, r_beats, r_upd, r_ns);
      run_snoop(op, st, gd, cd, rdy, addr, 0);
      check_txn($sformatf("rnd%0d op%0h st%0d", n, op, st), r_resp, r_beats, r_upd, r_ns, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
